// File: rtl/gray_step_scheduler_pkg.sv
// rtl/gray_step_scheduler_pkg.sv - shared constants and helpers for the Gray step scheduler
// Purpose: FSM state encodings, default sizing constants and the bin-to-Gray helper.
// Ports: none (package).
package gray_sched_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] STEP = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int NREQ_DEF = 4;
  localparam int CW_DEF   = 3;
  localparam int LW_DEF   = 3;

  // Wide enough for any supported counter width; callers truncate.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_step_scheduler_if.sv
// rtl/gray_step_scheduler_if.sv - request/result bundle between clients and the scheduler
// Purpose: groups the request handshake, debug step/gray view and the done result.
// Ports: master = client side (drives req_valid, req_len, done_ready);
//        slave  = scheduler side (drives req_ready, step, gray_q, busy, done_*).
interface gray_step_if #(
  parameter int NREQ = 4,
  parameter int CW   = 3,
  parameter int LW   = 3,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*LW-1:0] req_len;
  logic [NREQ-1:0]    req_ready;
  logic               step;
  logic [CW-1:0]      gray_q;
  logic               busy;
  logic               done_valid;
  logic               done_ready;
  logic [IDW-1:0]     done_id;
  logic [CW-1:0]      done_gray;
  logic               done_wrap;

  modport master (
    output req_valid, req_len, done_ready,
    input  req_ready, step, gray_q, busy, done_valid, done_id, done_gray, done_wrap
  );

  modport slave (
    input  req_valid, req_len, done_ready,
    output req_ready, step, gray_q, busy, done_valid, done_id, done_gray, done_wrap
  );
endinterface

// File: rtl/gray_step_scheduler_counter.sv
// rtl/gray_step_scheduler_counter.sv - shared binary counter with Gray-coded output
// Purpose: holds the binary count, advances on step, presents the Gray view.
// Ports: clk, reset (sync, active-low), step (advance), gray_q (Gray value),
//        wrap (combinational: this step rolls the top code over to 0).
module gray_step_counter
  import gray_sched_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step,
  output logic [CW-1:0] gray_q,
  output logic          wrap
);

  logic [CW-1:0] bin_q;
  logic [CW-1:0] bin_d;

  always_comb begin
    bin_d = bin_q;
    if (step) bin_d = bin_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) bin_q <= '0;
    else        bin_q <= bin_d;
  end

  assign gray_q = CW'(bin2gray(32'(bin_q)));
  assign wrap   = step & (bin_q == '1);

endmodule

// File: rtl/gray_step_scheduler.sv
// rtl/gray_step_scheduler.sv - round-robin job scheduler driving a shared Gray step counter
// Purpose: arbitrates step jobs from NREQ clients, issues one step pulse per requested
//          advance and reports the resulting Gray value, wrap flag and requester id.
// Ports: clk, reset (sync, active-low), bus (gray_step_if slave: request handshake,
//        step/gray_q/busy debug view, done result handshake).
module gray_step_scheduler
  import gray_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int CW   = CW_DEF,
  parameter int LW   = LW_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic        clk,
  input logic        reset,
  gray_step_if.slave bus
);

  logic [1:0]      state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [LW-1:0]   rem_q, rem_d;
  logic            wrap_q, wrap_d;

  logic [IDW-1:0]  winner;
  logic [IDW-1:0]  idx;
  logic            any_req;
  logic [LW-1:0]   win_len;
  logic            accept;

  logic [NREQ-1:0] req_ready_c;
  logic            step_c;
  logic            busy_c;
  logic            done_valid_c;
  logic [CW-1:0]   gray_w;
  logic            cnt_wrap;

  gray_step_counter #(.CW(CW)) u_counter (
    .clk    (clk),
    .reset  (reset),
    .step   (step_c),
    .gray_q (gray_w),
    .wrap   (cnt_wrap)
  );

  // Search starts just after the last winner so every client gets a turn.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (!any_req && bus.req_valid[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

  assign win_len = bus.req_len[winner*LW +: LW];
  assign accept  = |(bus.req_valid & req_ready_c);

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = (win_len != '0) ? STEP : DONE;
      STEP:    if (rem_q == LW'(1)) state_d = DONE;
      DONE:    if (bus.done_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // req_ready is gated by reset so nothing looks accepted while reset is held.
  always_comb begin
    req_ready_c = '0;
    if (reset && (state_q == IDLE) && any_req) req_ready_c[winner] = 1'b1;
    step_c       = (state_q == STEP);
    busy_c       = (state_q != IDLE);
    done_valid_c = (state_q == DONE);
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    rem_d    = rem_q;
    wrap_d   = wrap_q;
    if (accept) begin
      rr_ptr_d = winner;
      id_d     = winner;
      rem_d    = win_len;
      wrap_d   = 1'b0;
    end
    if (step_c) begin
      rem_d = rem_q - LW'(1);
      if (cnt_wrap) wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q <= IDW'(NREQ - 1);
      id_q     <= '0;
      rem_q    <= '0;
      wrap_q   <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      rem_q    <= rem_d;
      wrap_q   <= wrap_d;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.step       = step_c;
  assign bus.gray_q     = gray_w;
  assign bus.busy       = busy_c;
  assign bus.done_valid = done_valid_c;
  assign bus.done_id    = id_q;
  assign bus.done_gray  = gray_w;
  assign bus.done_wrap  = wrap_q;

endmodule

// File: doc/gray_step_scheduler.md
Name: gray_step_scheduler

Overview:
- Shares one CW-bit Gray-code step counter among NREQ requesters.
- Each requester asks for a number of counter advances. A round-robin arbiter grants one job at a time, and an FSM issues that many single-cycle step pulses to the counter.
- On completion the block reports the resulting Gray value, a wrap flag and the requester id.
- It sits between client blocks and the shared Gray counter resource.

Parameters:
- NREQ, 4: number of requesters (2..8).
- CW, 3: Gray counter width.
- LW, 3: width of each step-count field (0..2^LW-1 steps per job).
- IDW, 2: id width, equal to clog2(NREQ).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- req_valid  in  NREQ  per-requester job request.
- req_len  in  NREQ*LW  step count; requester i occupies bits [i*LW +: LW].
- req_ready  out  NREQ  one-hot accept pulse.
- step  out  1  advance pulse to the counter, visible for debug.
- gray_q  out  CW  current counter value in Gray code.
- busy  out  1  high in every state other than IDLE.
- done_valid  out  1  job-complete result valid.
- done_ready  in  1  consumer accepts the result.
- done_id  out  IDW  id of the finished requester.
- done_gray  out  CW  counter value at completion.
- done_wrap  out  1  counter passed top code to 0 at least once during the job.

Behaviour:
- Reset (reset==0 at posedge) has priority over everything else:
  - state=IDLE, internal binary count=0, gray_q=0, step=0, done_valid=0, done_id=0, done_gray=0, done_wrap=0, req_ready=0, rr_ptr=NREQ-1.
  - Asserting reset mid-job aborts the job. No done_valid is issued, and the requester is not re-granted unless it still asserts req_valid.
- Gray encoding: gray_q = bin ^ (bin>>1). For CW=3 the sequence is 000,001,011,010,110,111,101,100,000.
- FSM states: IDLE, STEP, DONE.
- IDLE:
  - If any req_valid is high, the winner is the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - req_ready[winner]=1 combinationally in that cycle, and only in that cycle. The handshake completes when req_valid and req_ready are both high.
  - On that edge: latch id and len, set rr_ptr=winner, clear the wrap flag.
  - Next state is STEP if len!=0, otherwise DONE.
  - If no req_valid is high, stay in IDLE.
- STEP:
  - step=1 every cycle. bin increments modulo 2^CW, and remaining decrements.
  - If bin is all-ones when the step occurs, set the wrap flag.
  - On the cycle with remaining==1, go to DONE.
  - No new request is accepted; req_ready=0.
- DONE:
  - done_valid=1, with done_id, done_gray (=gray_q) and done_wrap held stable.
  - Hold until done_ready=1, then go to IDLE.
  - step=0 throughout DONE.
- Latency: acceptance at edge t produces steps in cycles t+1..t+len, and done_valid is first high in cycle t+len+1. For len=0, done_valid is high in cycle t+1.
- Requesters must hold req_valid and req_len stable until accepted. A request dropped before acceptance is simply not served.
- All-requesters-valid case: grants rotate strictly 0,1,2,...,NREQ-1,0,... Bandwidth is one job per (len+2) cycles minimum with done_ready tied high.
- The counter is never reset between jobs; each job continues from the previous value.

Decomposition:
- Shared package gray_sched_pkg holds:
  - state encoding constants: IDLE=2'd0, STEP=2'd1, DONE=2'd2;
  - the default CW, LW and NREQ constants;
  - a bin-to-Gray conversion function.
- One sub-module, gray_step_counter, with ports clk, reset, step, gray_q and wrap. It holds the binary register and Gray conversion. wrap is combinational: step & (bin == all-ones).
- The arbiter and FSM stay in gray_step_scheduler.

Test Plan:
- Release reset; req_valid=0001, len0=3 -> req_ready=0001 for one cycle; step high 3 cycles; done_valid with done_id=0, done_gray=010, done_wrap=0.
- From gray 010: req_valid=0010, len1=6 -> gray passes 110,111,101,100,000,001; done_gray=001, done_id=1, done_wrap=1.
- req_valid=1111 with all lengths=1 and done_ready=1 held, starting from reset -> grant order 0,1,2,3,0 (first grant to requester 0 because rr_ptr=3); one step per job; gray advances by 1 per job.
- len2=0 with req_valid=0100 -> done_valid one cycle after accept; done_gray unchanged; done_wrap=0; step never asserted.
- done_ready held at 0 for 5 cycles in DONE with req_valid=1111 -> done outputs stable, req_ready=0, step=0, busy=1; accept resumes the cycle after done_ready=1.
- reset driven to 0 during STEP (2 of 5 steps done) -> next cycle: state IDLE, gray_q=000, done_valid=0, step=0; the aborted job produces no result.
